// File: rtl/bus_priority_encoder.sv
// Registered priority encoder for bus-source request lines, with sample/hold control.
// Optional multi-hot detection (err pulse, saturating err_cnt) is enabled by BUS_ENC_MULTIHOT_ERR_EN.
module bus_priority_encoder #(
    parameter int N_SRC     = 32,
    parameter int SEL_W     = 5,
    parameter int PRIO_HIGH = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_SRC-1:0] req,
    input  logic             en,
    input  logic             hold,
    output logic [SEL_W-1:0] sel,
    output logic             sel_vld,
    output logic             chg,
    output logic             err,
    output logic [7:0]       err_cnt
);

    logic [SEL_W-1:0] win;
    logic             any;
    logic             sample;

    assign any    = |req;
    assign sample = en && !hold;

    // The req port is exactly N_SRC wide, so unused select codes can never win.
    always_comb begin
        win = '0;
        if (PRIO_HIGH != 0) begin
            for (int i = 0; i < N_SRC; i++)
                if (req[i]) win = SEL_W'(i);
        end else begin
            for (int i = N_SRC - 1; i >= 0; i--)
                if (req[i]) win = SEL_W'(i);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sel     <= '0;
            sel_vld <= 1'b0;
            chg     <= 1'b0;
        end else if (hold) begin
            chg <= 1'b0;
        end else if (!en) begin
            sel_vld <= 1'b0;
            chg     <= 1'b0;
        end else if (any) begin
            sel     <= win;
            sel_vld <= 1'b1;
            chg     <= !sel_vld || (win != sel);
        end else begin
            sel_vld <= 1'b0;
            chg     <= 1'b0;
        end
    end

`ifdef BUS_ENC_MULTIHOT_ERR_EN
    logic multi;

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign multi = |(req & (req - N_SRC'(1)));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (!sample) begin
            err <= 1'b0;
        end else begin
            err <= multi;
            if (multi && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    logic unused_sample;

    assign unused_sample = sample;
    assign err           = 1'b0;
    assign err_cnt       = '0;
`endif

endmodule

// File: tb/tb_bus_priority_encoder.sv
// Directed bench for bus_priority_encoder: a low-priority and a high-priority instance share inputs,
// a behavioural model is compared every cycle, and literal expectations pin key points.
module tb_bus_priority_encoder;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] req = '0;
    logic        en  = 1'b0;
    logic        hold = 1'b0;

    logic [4:0] sel_lo, sel_hi;
    logic       vld_lo, vld_hi, chg_lo, chg_hi, err_lo, err_hi;
    logic [7:0] cnt_lo, cnt_hi;

    int checks = 0;
    int errors = 0;
    bit running = 1'b0;

    bus_priority_encoder #(.N_SRC(32), .SEL_W(5), .PRIO_HIGH(0)) dut_lo (
        .clk(clk), .clr(clr), .req(req), .en(en), .hold(hold),
        .sel(sel_lo), .sel_vld(vld_lo), .chg(chg_lo), .err(err_lo), .err_cnt(cnt_lo));

    bus_priority_encoder #(.N_SRC(32), .SEL_W(5), .PRIO_HIGH(1)) dut_hi (
        .clk(clk), .clr(clr), .req(req), .en(en), .hold(hold),
        .sel(sel_hi), .sel_vld(vld_hi), .chg(chg_hi), .err(err_hi), .err_cnt(cnt_hi));

    always #5 clk = ~clk;

    // Behavioural model: winners from bit arithmetic, multi-hot from a popcount.
    int m_sel_lo, m_sel_hi, m_cnt;
    bit m_vld, m_chg_lo, m_chg_hi, m_err;

    always @(posedge clk or posedge clr) begin
        longint r;
        int lo, hi;
        if (clr) begin
            m_sel_lo <= 0; m_sel_hi <= 0; m_vld <= 0;
            m_chg_lo <= 0; m_chg_hi <= 0; m_err <= 0; m_cnt <= 0;
        end else if (hold) begin
            m_chg_lo <= 0; m_chg_hi <= 0; m_err <= 0;
        end else if (!en) begin
            m_vld <= 0; m_chg_lo <= 0; m_chg_hi <= 0; m_err <= 0;
        end else begin
            r = longint'(req);
            m_err <= 0;
            if (r != 0) begin
                lo = $clog2(r & (~r + 1));
                hi = $clog2(r + 1) - 1;
                m_chg_lo <= !m_vld || (lo != m_sel_lo);
                m_chg_hi <= !m_vld || (hi != m_sel_hi);
                m_sel_lo <= lo;
                m_sel_hi <= hi;
                m_vld    <= 1;
            end else begin
                m_vld <= 0; m_chg_lo <= 0; m_chg_hi <= 0;
            end
`ifdef BUS_ENC_MULTIHOT_ERR_EN
            if ($countones(req) > 1) begin
                m_err <= 1;
                if (m_cnt < 255) m_cnt <= m_cnt + 1;
            end
`endif
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (running && !clr) begin
            chk("model sel_lo", 64'(sel_lo), 64'(m_sel_lo));
            chk("model sel_hi", 64'(sel_hi), 64'(m_sel_hi));
            chk("model vld_lo", 64'(vld_lo), 64'(m_vld));
            chk("model vld_hi", 64'(vld_hi), 64'(m_vld));
            chk("model chg_lo", 64'(chg_lo), 64'(m_chg_lo));
            chk("model chg_hi", 64'(chg_hi), 64'(m_chg_hi));
            chk("model err_lo", 64'(err_lo), 64'(m_err));
            chk("model err_hi", 64'(err_hi), 64'(m_err));
            chk("model cnt_lo", 64'(cnt_lo), 64'(m_cnt));
            chk("model cnt_hi", 64'(cnt_hi), 64'(m_cnt));
        end
    end

    // Apply inputs, then return just after the edge that samples them.
    task automatic drive(input logic [31:0] r, input logic e, input logic h);
        req = r; en = e; hold = h;
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string nm, input int s_lo, input int s_hi, input bit v, input bit c);
        chk({nm, " sel_lo"}, 64'(sel_lo), 64'(s_lo));
        chk({nm, " sel_hi"}, 64'(sel_hi), 64'(s_hi));
        chk({nm, " vld"}, 64'(vld_lo), 64'(v));
        chk({nm, " chg"}, 64'(chg_lo), 64'(c));
    endtask

    initial begin
        logic [31:0] one;
        #3;
        chk("reset sel", 64'({sel_lo, sel_hi}), 64'd0);
        chk("reset vld_chg", 64'({vld_lo, vld_hi, chg_lo, chg_hi}), 64'd0);
        chk("reset err", 64'({err_lo, err_hi, cnt_lo, cnt_hi}), 64'd0);
        #9;
        clr = 1'b0;
        running = 1'b1;

        // One-hot sweep: every cycle a new source, so chg every cycle.
        for (int k = 0; k < 32; k++) begin
            one = 32'd1 << k;
            drive(one, 1'b1, 1'b0);
            pin("sweep", k, k, 1'b1, 1'b1);
        end

        // Two requesters: 8 and 11.
        drive(32'h0000_0900, 1'b1, 1'b0);
        pin("prio", 8, 11, 1'b1, 1'b1);
`ifdef BUS_ENC_MULTIHOT_ERR_EN
        chk("prio err", 64'(err_lo), 64'd1);
        chk("prio cnt", 64'(cnt_lo), 64'd1);
`else
        chk("prio err", 64'(err_lo), 64'd0);
        chk("prio cnt", 64'(cnt_lo), 64'd0);
`endif

        // Idle then hold.
        drive(32'h10, 1'b1, 1'b0);
        pin("idle a", 4, 4, 1'b1, 1'b1);
        drive(32'h0, 1'b1, 1'b0);
        pin("idle b", 4, 4, 1'b0, 1'b0);
        drive(32'h8000, 1'b1, 1'b1);
        pin("hold", 4, 4, 1'b0, 1'b0);

        // Same source three times.
        drive(32'h20, 1'b1, 1'b0);
        pin("rep 1", 5, 5, 1'b1, 1'b1);
        drive(32'h20, 1'b1, 1'b0);
        pin("rep 2", 5, 5, 1'b1, 1'b0);
        drive(32'h20, 1'b1, 1'b0);
        pin("rep 3", 5, 5, 1'b1, 1'b0);

        // en low drops valid; a repeat after that counts as a change.
        drive(32'h40, 1'b0, 1'b0);
        pin("en off", 5, 5, 1'b0, 1'b0);
        drive(32'h20, 1'b1, 1'b0);
        pin("en back", 5, 5, 1'b1, 1'b1);
        drive(32'h40, 1'b1, 1'b1);
        pin("hold vld", 5, 5, 1'b1, 1'b0);

        // Multi-hot saturation.
        for (int i = 0; i < 300; i++) drive(32'h3, 1'b1, 1'b0);
        pin("sat", 0, 1, 1'b1, 1'b0);
`ifdef BUS_ENC_MULTIHOT_ERR_EN
        chk("sat cnt", 64'(cnt_lo), 64'd255);
        chk("sat err", 64'(err_lo), 64'd1);
`else
        chk("sat cnt", 64'(cnt_lo), 64'd0);
`endif
        drive(32'h3, 1'b1, 1'b1);
        chk("hold cnt", 64'(cnt_lo), 64'(m_cnt));
        chk("hold err", 64'(err_lo), 64'd0);

        // Asynchronous clear between edges.
        drive(32'h200, 1'b1, 1'b0);
        pin("pre clr", 9, 9, 1'b1, 1'b1);
        #2 clr = 1'b1;
        #1;
        chk("clr sel", 64'({sel_lo, sel_hi}), 64'd0);
        chk("clr vld_chg", 64'({vld_lo, vld_hi, chg_lo, chg_hi}), 64'd0);
        chk("clr err", 64'({err_lo, err_hi, cnt_lo, cnt_hi}), 64'd0);
        clr = 1'b0;
        drive(32'h200, 1'b1, 1'b0);
        pin("post clr", 9, 9, 1'b1, 1'b1);

        drive(32'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
